// File: rtl/func_sweep_ctrl.sv
// rtl/func_sweep_ctrl.sv - on-chip exhaustive sweep of a combinational function block
// against a golden truth table; define FUNC_SWEEP_ABORT_EN to end the sweep at the first mismatch.
module func_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      vec,
  input  logic                 y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   truth_table,
  output logic [N_IN:0]        err_cnt,
  output logic [N_IN-1:0]      fail_idx
);

  localparam int NV = 2**N_IN;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [7:0]      settle_q, settle_d;
  logic [NV-1:0]   exp_q, exp_d;
  logic [NV-1:0]   tt_q, tt_d;
  logic [N_IN:0]   err_q, err_d;
  logic            pass_q, pass_d;
  logic [N_IN-1:0] fail_q, fail_d;
  logic            first_q, first_d;
  logic            mismatch;
  logic            abort_now;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    exp_d     = exp_q;
    tt_d      = tt_q;
    err_d     = err_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    first_d   = first_q;
    mismatch  = (y != exp_q[idx_q]);
`ifdef FUNC_SWEEP_ABORT_EN
    abort_now = mismatch && !first_q;
`else
    abort_now = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d    = '0;
          settle_d = 8'(SETTLE);
          exp_d    = expected;
          tt_d     = '0;
          err_d    = '0;
          pass_d   = 1'b0;
          fail_d   = '0;
          first_d  = 1'b0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (settle_q <= 8'd1) state_d = S_SAMPLE;
        else                  settle_d = settle_q - 8'd1;
      end
      S_SAMPLE: begin
        tt_d[idx_q] = y;
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!first_q) begin
            fail_d  = idx_q;
            first_d = 1'b1;
          end
        end
        // pass is resolved here, including this sample, so it is final in the done cycle
        if (idx_q == N_IN'(NV - 1) || abort_now) begin
          pass_d  = (err_d == '0);
          state_d = S_DONE;
        end else begin
          idx_d    = idx_q + 1'b1;
          settle_d = 8'(SETTLE);
          state_d  = S_WAIT;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      exp_q    <= '0;
      tt_q     <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
      fail_q   <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      exp_q    <= exp_d;
      tt_q     <= tt_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      first_q  <= first_d;
    end
  end

  assign vec         = idx_q;
  assign busy        = (state_q == S_WAIT) || (state_q == S_SAMPLE);
  assign done        = (state_q == S_DONE);
  assign pass        = pass_q;
  assign truth_table = tt_q;
  assign err_cnt     = err_q;
  assign fail_idx    = fail_q;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// tb/tb_func_sweep_ctrl.sv - directed bench: y=a&b&c&d at SETTLE=1 and y=a^d at SETTLE=3.
module tb_func_sweep_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start;
  logic [15:0] exp1, exp3;
  logic [3:0]  vec1, vec3, fail1, fail3;
  logic        y1, y3, busy1, busy3, done1, done3, pass1, pass3;
  logic [15:0] tt1, tt3;
  logic [4:0]  err1, err3;

  assign y1 = &vec1;
  assign y3 = vec3[3] ^ vec3[0];

  func_sweep_ctrl #(.N_IN(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .expected(exp1), .vec(vec1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .truth_table(tt1), .err_cnt(err1), .fail_idx(fail1));

  func_sweep_ctrl #(.N_IN(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .expected(exp3), .vec(vec3), .y(y3),
    .busy(busy3), .done(done3), .pass(pass3), .truth_table(tt3), .err_cnt(err3), .fail_idx(fail3));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one sweep on both DUTs; DUT1 results are snapshotted in its done cycle.
  task automatic sweep(input logic [15:0] m1, input logic [15:0] m3, input int repulse,
                       output int d1, output int d3, output int verr1, output int verr3,
                       output logic p1, output logic [4:0] e1, output logic [3:0] f1,
                       output logic [15:0] t1);
    int cyc;
    d1 = -1; d3 = -1; verr1 = 0; verr3 = 0;
    p1 = 1'bx; e1 = 'x; f1 = 'x; t1 = 'x;
    @(negedge clk); start = 1'b1; exp1 = m1; exp3 = m3;
    @(negedge clk); cyc = 1;
    while (cyc <= 150 && (d1 < 0 || d3 < 0)) begin
      start = (cyc == repulse);
      if (cyc == repulse) begin exp1 = ~m1; exp3 = ~m3; end
      if (busy1 && vec1 !== 4'((cyc - 1) / 2)) verr1++;
      if (busy3 && vec3 !== 4'((cyc - 1) / 4)) verr3++;
      if (done1 && d1 < 0) begin d1 = cyc; p1 = pass1; e1 = err1; f1 = fail1; t1 = tt1; end
      if (done3 && d3 < 0) d3 = cyc;
      @(negedge clk); cyc++;
    end
    start = 1'b0;
  endtask

  int d1, d3, ve1, ve3, cyc, ndone;
  logic p1;
  logic [4:0] e1;
  logic [3:0] f1;
  logic [15:0] t1;

  initial begin
    rst_n = 1'b0; start = 1'b0; exp1 = '0; exp3 = '0;
    repeat (2) @(negedge clk);
    chk("rst_vec", vec1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_tt", tt1, 0);
    chk("rst_err", err1, 0);
    chk("rst_fail", fail1, 0);
    rst_n = 1'b1;

    sweep(16'h8000, 16'h55AA, 0, d1, d3, ve1, ve3, p1, e1, f1, t1);
    chk("a_done_cyc", d1, 33);
    chk("a_pass", p1, 1);
    chk("a_err", e1, 0);
    chk("a_fail", f1, 0);
    chk("a_tt", t1, 16'h8000);
    chk("a_vec_seq", ve1, 0);
    chk("a_vec_hold", vec1, 15);
    chk("a_tt_hold", tt1, 16'h8000);
    chk("s3_done_cyc", d3, 65);
    chk("s3_pass", pass3, 1);
    chk("s3_err", err3, 0);
    chk("s3_tt", tt3, 16'h55AA);
    chk("s3_vec_seq", ve3, 0);

    sweep(16'h8081, 16'h55AA, 0, d1, d3, ve1, ve3, p1, e1, f1, t1);
`ifdef FUNC_SWEEP_ABORT_EN
    chk("b_done_cyc", d1, 3);
    chk("b_err", e1, 1);
    chk("b_tt", t1, 16'h0000);
`else
    chk("b_done_cyc", d1, 33);
    chk("b_err", e1, 2);
    chk("b_tt", t1, 16'h8000);
`endif
    chk("b_pass", p1, 0);
    chk("b_fail", f1, 0);
    chk("b_vec_seq", ve1, 0);

    sweep(16'h8000, 16'h55AA, 10, d1, d3, ve1, ve3, p1, e1, f1, t1);
    chk("c_done_cyc", d1, 33);
    chk("c_pass", p1, 1);
    chk("c_err", e1, 0);
    chk("c_tt", t1, 16'h8000);
    chk("c_s3_done_cyc", d3, 65);
    chk("c_s3_pass", pass3, 1);

    @(negedge clk); start = 1'b1; exp1 = 16'h8000; exp3 = 16'h55AA;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (cyc < 12) begin @(negedge clk); cyc++; end
    rst_n = 1'b0;
    @(negedge clk);
    chk("r_vec", vec1, 0);
    chk("r_busy", busy1, 0);
    chk("r_done", done1, 0);
    chk("r_err", err1, 0);
    chk("r_pass", pass1, 0);
    chk("r_tt", tt1, 0);
    chk("r_busy3", busy3, 0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (80) begin
      @(negedge clk);
      if (done1 || done3 || busy1 || busy3) ndone++;
    end
    chk("r_no_done", ndone, 0);

    sweep(16'h8000, 16'h55AA, 0, d1, d3, ve1, ve3, p1, e1, f1, t1);
    chk("r2_done_cyc", d1, 33);
    chk("r2_pass", p1, 1);
    chk("r2_tt", t1, 16'h8000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
